common_cells_counter: RTL and testbench
=======================================

Name: common_cells_counter

Overview:
- Parameterizable synchronous up/down counter with synchronous clear, parallel load and an overflow/underflow flag.
- Used as the per-bucket counter and the total-item counter inside the counting bloom filter.
- Also a general-purpose counter for other common-cells blocks.
- Holds one WIDTH-bit count plus one extra wrap bit.

Parameters:
- WIDTH, 4, width of the count output q_o and of the load value d_i; must be >= 1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset; synchronous, active-high. The port name is kept for codebase compatibility; the level is high-active.
- clear_i  input  1  synchronous clear of count and overflow flag.
- en_i  input  1  count enable (step of 1).
- load_i  input  1  parallel load of d_i.
- down_i  input  1  direction when en_i=1: 1 = decrement, 0 = increment.
- d_i  input  WIDTH  load value.
- q_o  output  WIDTH  current count.
- overflow_o  output  1  wrap flag.

Behaviour:
- Internal state: cnt_q of WIDTH+1 bits. q_o = cnt_q[WIDTH-1:0]; overflow_o = cnt_q[WIDTH]. Both outputs are purely registered, with no combinational path from inputs.
- Reset: when rst_ni=1 at a rising edge, cnt_q <= 0, so q_o=0 and overflow_o=0. Reset has the highest priority and overrides any other input in the same cycle.
- Priority per edge: reset > clear_i > load_i > en_i > hold.
  - clear_i=1: cnt_q <= 0.
  - load_i=1: cnt_q <= {1'b0, d_i}. The overflow flag is cleared on load.
  - en_i=1, down_i=0: cnt_q <= cnt_q + 1, modulo 2^(WIDTH+1).
  - en_i=1, down_i=1: cnt_q <= cnt_q - 1, modulo 2^(WIDTH+1).
  - Otherwise cnt_q holds.
- down_i is ignored when en_i=0.
- Latency: every operation is visible on q_o and overflow_o one cycle after the enabling edge.
- Wrap-around:
  - Incrementing from q_o = 2^WIDTH-1 with overflow_o=0 gives q_o=0, overflow_o=1.
  - Decrementing from q_o=0 with overflow_o=0 gives q_o = 2^WIDTH-1, overflow_o=1 (underflow is also flagged).
- The flag is non-sticky, i.e. arithmetic on the (WIDTH+1)-bit value.
  - A further increment from {1, all-ones} returns to {0, 0}.
  - Decrementing from {1, 0} returns to {0, all-ones}.
  - Consequently an overflow followed by a matching underflow clears the flag.
- Reset or clear mid-count: takes effect on the next edge regardless of en_i, load_i or d_i.

Decomposition:
- No shared package needed: the only configuration is WIDTH.
- Single flat module, no sub-modules.
- The consumer (bloom filter) ties load_i and d_i to 0 and uses the module as a plain up/down counter.

Test Plan:
- Reset/clear/load/hold:
  - Assert rst_ni=1 for 2 cycles with en_i=1, load_i=1 -> q_o=0, overflow_o=0.
  - Release, then en_i=1, down_i=0 for 3 cycles -> q_o = 1, 2, 3 on successive cycles.
  - Hold en_i=0 -> q_o stays 3.
- Load and priority (WIDTH=4):
  - load_i=1, d_i=4'hA -> q_o=10 next cycle.
  - Same cycle load_i=1, en_i=1 -> load wins, q_o=10.
  - clear_i=1 with load_i=1, d_i=5 -> q_o=0.
- Overflow (WIDTH=4):
  - Load 15, en_i=1 up -> q_o=0, overflow_o=1.
  - Further up -> q_o=1, overflow_o=1.
  - Then down twice -> q_o=15, overflow_o=0.
- Underflow (WIDTH=4):
  - From q_o=0, en_i=1, down_i=1 -> q_o=15, overflow_o=1.
  - clear_i=1 -> q_o=0, overflow_o=0 next cycle.
- Reset mid-operation:
  - Count up to 7, assert rst_ni=1 for one cycle while en_i=1 -> q_o=0 next cycle.
  - Counting resumes from 0 after release: 1, 2, ...
- Mixed random up/down/load/clear sequence against a (WIDTH+1)-bit reference model -> q_o and overflow_o match every cycle.

Source files
------------

// File: rtl/common_cells_counter.sv
// common_cells_counter
// WIDTH-bit synchronous up/down counter with clear, parallel load and a
// non-sticky wrap flag. The flag is bit WIDTH of a (WIDTH+1)-bit count, so
// an overflow followed by a matching underflow clears it again.
module common_cells_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             overflow_o
);

  localparam logic [WIDTH:0] CNT_ZERO = '0;
  localparam logic [WIDTH:0] CNT_ONE  = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] cnt_q;
  logic [WIDTH:0] cnt_d;

  // Next-count selection: clear beats load, load beats counting, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = CNT_ZERO;
    end else if (load_i) begin
      cnt_d = {1'b0, d_i};
    end else if (en_i) begin
      if (down_i) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Count register; the reset input is high-active despite its name.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o        = cnt_q[WIDTH-1:0];
  assign overflow_o = cnt_q[WIDTH];

endmodule

// File: tb/tb_common_cells_counter.sv
// tb_common_cells_counter
// Directed and random stimulus for common_cells_counter (WIDTH=4). A
// modulo-32 integer model predicts the count; a single compare process
// checks the DUT against the model every cycle and also against
// hand-computed literal expectations posted by the stimulus.
module tb_common_cells_counter;

  localparam int unsigned WIDTH = 4;
  localparam int MOD  = 1 << (WIDTH + 1);
  localparam int HALF = 1 << WIDTH;

  logic             clk_i;
  logic             rst_ni;
  logic             clear_i;
  logic             en_i;
  logic             load_i;
  logic             down_i;
  logic [WIDTH-1:0] d_i;
  logic [WIDTH-1:0] q_o;
  logic             overflow_o;

  int checks;
  int failures;

  int model_cnt;
  bit model_valid;

  bit          lit_pending;
  int          lit_q;
  int          lit_ov;
  string       lit_name;

  common_cells_counter #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .en_i       (en_i),
    .load_i     (load_i),
    .down_i     (down_i),
    .d_i        (d_i),
    .q_o        (q_o),
    .overflow_o (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: the count is an integer modulo 2^(WIDTH+1).
  always @(posedge clk_i) begin
    if (rst_ni === 1'b1) begin
      model_cnt   = 0;
      model_valid = 1'b1;
    end else if (clear_i) begin
      model_cnt = 0;
    end else if (load_i) begin
      model_cnt = int'(d_i);
    end else if (en_i) begin
      if (down_i) model_cnt = (model_cnt + MOD - 1) % MOD;
      else        model_cnt = (model_cnt + 1) % MOD;
    end
  end

  // Compare process: model check every cycle, plus any posted literal check.
  always @(negedge clk_i) begin
    if (model_valid) begin
      checks++;
      if (q_o !== WIDTH'(model_cnt % HALF) || overflow_o !== 1'(model_cnt / HALF)) begin
        failures++;
        $display("[TB] FAIL model: got q=%0d ov=%0b, expected q=%0d ov=%0d at %0t",
                 q_o, overflow_o, model_cnt % HALF, model_cnt / HALF, $time);
      end
    end
    if (lit_pending) begin
      checks++;
      if (q_o !== WIDTH'(lit_q) || overflow_o !== 1'(lit_ov)) begin
        failures++;
        $display("[TB] FAIL %s: got q=%0d ov=%0b, expected q=%0d ov=%0d",
                 lit_name, q_o, overflow_o, lit_q, lit_ov);
      end
    end
  end

  task automatic applyStimulus(input bit rst, input bit clr, input bit ld,
                               input bit en, input bit dn, input int d);
    rst_ni  = rst;
    clear_i = clr;
    load_i  = ld;
    en_i    = en;
    down_i  = dn;
    d_i     = WIDTH'(d);
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input int q, input int ov);
    lit_name    = name;
    lit_q       = q;
    lit_ov      = ov;
    lit_pending = 1'b1;
    @(negedge clk_i);
    #1;
    lit_pending = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    model_cnt   = 0;
    model_valid = 1'b0;
    lit_pending = 1'b0;
    rst_ni = 1'b0; clear_i = 1'b0; load_i = 1'b0;
    en_i = 1'b0; down_i = 1'b0; d_i = '0;
    @(negedge clk_i);

    // Reset overrides load and enable
    applyStimulus(1, 0, 1, 1, 0, 9); checkOutput("reset_1", 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 9); checkOutput("reset_2", 0, 0);

    // Count up, then hold
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("up_1", 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("up_2", 2, 0);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("up_3", 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("hold", 3, 0);
    applyStimulus(0, 0, 0, 0, 1, 0); checkOutput("hold_down_ignored", 3, 0);

    // Load and priority
    applyStimulus(0, 0, 1, 0, 0, 10); checkOutput("load_a", 10, 0);
    applyStimulus(0, 0, 1, 1, 0, 10); checkOutput("load_over_en", 10, 0);
    applyStimulus(0, 0, 1, 1, 1, 6);  checkOutput("load_over_down", 6, 0);
    applyStimulus(0, 1, 1, 1, 0, 5);  checkOutput("clear_over_load", 0, 0);

    // Overflow and recovery through decrement
    applyStimulus(0, 0, 1, 0, 0, 15); checkOutput("load_15", 15, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);  checkOutput("overflow", 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);  checkOutput("overflow_up", 1, 1);
    applyStimulus(0, 0, 0, 1, 1, 0);  checkOutput("overflow_down_1", 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 0);  checkOutput("overflow_down_2", 15, 0);

    // Underflow and clear
    applyStimulus(0, 1, 0, 0, 0, 0);  checkOutput("clear", 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);  checkOutput("underflow", 15, 1);
    applyStimulus(0, 1, 0, 1, 1, 0);  checkOutput("clear_flag", 0, 0);

    // Full wrap of the extended count: {1,15} + 1 -> {0,0}
    applyStimulus(0, 0, 1, 0, 0, 15);
    applyStimulus(0, 0, 0, 1, 0, 0);  checkOutput("wrap_start", 0, 1);
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);  checkOutput("wrap_top", 15, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);  checkOutput("wrap_zero", 0, 0);

    // Load clears flag
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 3);  checkOutput("load_clears_flag", 3, 0);

    // Reset mid-count
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("count_7", 7, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);  checkOutput("reset_mid", 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);  checkOutput("resume_1", 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);  checkOutput("resume_2", 2, 0);

    // Random mix checked by the model
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      applyStimulus(r < 2, (r >= 2 && r < 6), (r >= 6 && r < 14),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, HALF - 1)));
    end

    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
